// File: rtl/button_pkg.sv
// Shared types and constants for the push-button front end.
// Latency: n/a (types, constants and a constant helper only).
// Backpressure: n/a.
package button_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    REL    = 2'd0,
    PRS_DB = 2'd1,
    HELD   = 2'd2,
    REL_DB = 2'd3
  } btn_state_t;

  // Channel positions of the original five-button board front end.
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_CENTER = 4;

  // Larger of two integers, used to size the repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_bank_channel.sv
// One button channel: 2-FF synchroniser, tick-driven debounce FSM, press/release pulses.
// Latency: 2 clk sync, then press/release on the (DB_TICKS+1)th consecutive stable tick.
// Backpressure: none; pulses are one clk wide and must be consumed when seen.
// Optional hold-to-repeat is built when BUTTON_BANK_AUTOREPEAT_EN is defined.
module btn_channel
  import button_pkg::*;
#(
  parameter int DB_TICKS   = 10,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int DB_W = $clog2(DB_TICKS + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_TICKS);

  logic            sync1_q;
  logic            sync2_q;
  btn_state_t      state_q;
  logic [DB_W-1:0] cnt_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;
  logic            rpt_fire;

  // Two-flop synchroniser; only sync2_q is used by the debounce logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with registered level and one-cycle press/release pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= REL;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (tick_i) begin
        case (state_q)
          REL: begin
            if (sync2_q) begin
              state_q <= PRS_DB;
              cnt_q   <= DB_W'(1);
            end
          end
          PRS_DB: begin
            if (!sync2_q) begin
              state_q <= REL;
              cnt_q   <= '0;
            end else if (cnt_q == DB_MAX) begin
              state_q <= HELD;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HELD: begin
            if (!sync2_q) begin
              state_q <= REL_DB;
              cnt_q   <= DB_W'(1);
            end else if (rpt_fire) begin
              press_q <= 1'b1;
            end
          end
          REL_DB: begin
            if (sync2_q) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q == DB_MAX) begin
              state_q   <= REL;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= REL;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

`ifdef BUTTON_BANK_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(max_int(RPT_DELAY, RPT_PERIOD) + 1);

  logic [RPT_W-1:0] rpt_q;
  logic             rpt_armed_q;
  logic [RPT_W-1:0] rpt_inc;
  logic [RPT_W-1:0] rpt_tgt;

  // First repeat waits RPT_DELAY ticks, later ones RPT_PERIOD ticks.
  assign rpt_inc  = rpt_q + 1'b1;
  assign rpt_tgt  = rpt_armed_q ? RPT_W'(RPT_PERIOD) : RPT_W'(RPT_DELAY);
  assign rpt_fire = tick_i && (state_q == HELD) && sync2_q && (rpt_inc == rpt_tgt);

  // Repeat counter: runs in HELD, frozen in REL_DB, cleared on every way into HELD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else if (tick_i) begin
      case (state_q)
        HELD: begin
          if (sync2_q) begin
            if (rpt_fire) begin
              rpt_q       <= '0;
              rpt_armed_q <= 1'b1;
            end else begin
              rpt_q <= rpt_inc;
            end
          end
        end
        REL_DB: begin
          if (sync2_q) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
          end
        end
        default: begin
          rpt_q       <= '0;
          rpt_armed_q <= 1'b0;
        end
      endcase
    end
  end
`else
  // Single press per accepted press; no repeat state exists in this build.
  assign rpt_fire = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_bank.sv
// N-channel push-button conditioner: shared tick prescaler plus one btn_channel per pin.
// Latency: 2 clk sync + (DB_TICKS+1) ticks to accept a level change.
// Backpressure: none; press/release are single-cycle strobes.
// Hold-to-repeat is enabled by defining BUTTON_BANK_AUTOREPEAT_EN.
module button_bank
  import button_pkg::*;
#(
  parameter int N_BTN      = 5,
  parameter int TICK_DIV   = 100_000,
  parameter int DB_TICKS   = 10,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_in_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic             tick_o
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] div_q;
  logic [TICK_W-1:0] div_d;
  logic              tick;

  // Tick is the terminal count of the prescaler.
  assign tick  = (div_q == TICK_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Free-running prescaler, 0..TICK_DIV-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = tick;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_TICKS  (DB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick),
      .btn_i    (btn_in_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: expected pulses queued at stimulus time, observed pulses
// queued by a negedge monitor, then matched per scenario.
module tb_button_bank;
  import button_pkg::*;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RP = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] btn_in_i;
  logic [N-1:0] level_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic         tick_o;

  typedef struct {
    int           e;
    logic [N-1:0] p;
    logic [N-1:0] r;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  edge_n = 0;
  int  n_cmp  = 0;
  int  n_bad  = 0;

  button_bank #(
    .N_BTN     (N),
    .TICK_DIV  (TD),
    .DB_TICKS  (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .btn_in_i (btn_in_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .tick_o   (tick_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge index since the last reset edge (the reset edge itself is 0).
  always @(posedge clk_i) begin
    if (rst_i) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // Monitor: every cycle carrying a pulse becomes one observed event.
  always @(negedge clk_i) begin
    if (!rst_i && ((press_o | release_o) != '0))
      obs_q.push_back('{edge_n, press_o, release_o});
  end

  // Edge at which a pin change applied just after edge a is accepted:
  // s follows 3 edges later, first tick edge is the next multiple of TD,
  // then DB further ticks of stability.
  function automatic int accept_edge(input int a);
    int t1;
    t1 = ((a + 3 + TD - 1) / TD) * TD;
    return t1 + DB * TD;
  endfunction

  function automatic int first_tick(input int a);
    return ((a + 3 + TD - 1) / TD) * TD;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    btn_in_i = '0;
    step(3);
    n_cmp++; if (level_o !== '0)   begin n_bad++; $display("FAIL reset_level: got %b want 0", level_o); end
    n_cmp++; if (press_o !== '0)   begin n_bad++; $display("FAIL reset_press: got %b want 0", press_o); end
    n_cmp++; if (release_o !== '0) begin n_bad++; $display("FAIL reset_release: got %b want 0", release_o); end
    n_cmp++; if (tick_o !== 1'b0)  begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick_o); end
    rst_i = 1'b0;
    step(1);
  endtask

  task automatic test_clean_press_release();
    int  a;
    ev_t x, o;
    a = edge_n;
    btn_in_i[BTN_UP] = 1'b1;
    exp_q.push_back('{accept_edge(a), 5'b00001, 5'b00000});
    step(40);
    n_cmp++; if (level_o !== 5'b00001) begin n_bad++; $display("FAIL press_level: got %b want 00001", level_o); end
    a = edge_n;
    btn_in_i[BTN_UP] = 1'b0;
    exp_q.push_back('{accept_edge(a), 5'b00000, 5'b00001});
    step(40);
    n_cmp++; if (level_o !== 5'b00000) begin n_bad++; $display("FAIL release_level: got %b want 00000", level_o); end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL clean_press: no pulse, want edge %0d press %b release %b", x.e, x.p, x.r);
      end else begin
        o = obs_q.pop_front();
        if (o.e !== x.e || o.p !== x.p || o.r !== x.r) begin
          n_bad++;
          $display("FAIL clean_press: got edge %0d press %b release %b, want edge %0d press %b release %b",
                   o.e, o.p, o.r, x.e, x.p, x.r);
        end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL clean_press_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_bounce();
    int  a;
    ev_t x, o;
    btn_in_i[BTN_RIGHT] = 1'b1;
    step(TD);
    btn_in_i[BTN_RIGHT] = 1'b0;
    step(TD);
    a = edge_n;
    btn_in_i[BTN_RIGHT] = 1'b1;
    exp_q.push_back('{accept_edge(a), 5'b00100, 5'b00000});
    step(40);
    n_cmp++; if (level_o !== 5'b00100) begin n_bad++; $display("FAIL bounce_level: got %b want 00100", level_o); end
    a = edge_n;
    btn_in_i[BTN_RIGHT] = 1'b0;
    exp_q.push_back('{accept_edge(a), 5'b00000, 5'b00100});
    step(40);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL bounce: no pulse, want edge %0d press %b release %b", x.e, x.p, x.r);
      end else begin
        o = obs_q.pop_front();
        if (o.e !== x.e || o.p !== x.p || o.r !== x.r) begin
          n_bad++;
          $display("FAIL bounce: got edge %0d press %b release %b, want edge %0d press %b release %b",
                   o.e, o.p, o.r, x.e, x.p, x.r);
        end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL bounce_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_simultaneous();
    int  a;
    ev_t x, o;
    a = edge_n;
    btn_in_i = 5'b10001;
    exp_q.push_back('{accept_edge(a), 5'b10001, 5'b00000});
    step(30);
    n_cmp++; if (level_o !== 5'b10001) begin n_bad++; $display("FAIL simul_level: got %b want 10001", level_o); end
    a = edge_n;
    btn_in_i = 5'b00000;
    exp_q.push_back('{accept_edge(a), 5'b00000, 5'b10001});
    step(30);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL simul: no pulse, want edge %0d press %b release %b", x.e, x.p, x.r);
      end else begin
        o = obs_q.pop_front();
        if (o.e !== x.e || o.p !== x.p || o.r !== x.r) begin
          n_bad++;
          $display("FAIL simul: got edge %0d press %b release %b, want edge %0d press %b release %b",
                   o.e, o.p, o.r, x.e, x.p, x.r);
        end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL simul_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_debounce();
    int  a;
    int  t1;
    ev_t x, o;
    a = edge_n;
    btn_in_i[BTN_DOWN] = 1'b1;
    t1 = first_tick(a);
    step(t1 + TD - a);
    rst_i = 1'b1;
    step(1);
    n_cmp++; if (level_o !== '0)   begin n_bad++; $display("FAIL midrst_level: got %b want 0", level_o); end
    n_cmp++; if (press_o !== '0)   begin n_bad++; $display("FAIL midrst_press: got %b want 0", press_o); end
    n_cmp++; if (release_o !== '0) begin n_bad++; $display("FAIL midrst_release: got %b want 0", release_o); end
    n_cmp++; if (tick_o !== 1'b0)  begin n_bad++; $display("FAIL midrst_tick: got %b want 0", tick_o); end
    rst_i = 1'b0;
    exp_q.push_back('{(DB + 1) * TD, 5'b00010, 5'b00000});
    step(30);
    n_cmp++; if (level_o !== 5'b00010) begin n_bad++; $display("FAIL midrst_level_after: got %b want 00010", level_o); end
    a = edge_n;
    btn_in_i[BTN_DOWN] = 1'b0;
    exp_q.push_back('{accept_edge(a), 5'b00000, 5'b00010});
    step(30);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL midrst: no pulse, want edge %0d press %b release %b", x.e, x.p, x.r);
      end else begin
        o = obs_q.pop_front();
        if (o.e !== x.e || o.p !== x.p || o.r !== x.r) begin
          n_bad++;
          $display("FAIL midrst: got edge %0d press %b release %b, want edge %0d press %b release %b",
                   o.e, o.p, o.r, x.e, x.p, x.r);
        end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midrst_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_autorepeat();
    int  a;
    int  b;
    int  t_acc;
    int  t_rel;
    ev_t x, o;
    a = edge_n;
    btn_in_i[BTN_LEFT] = 1'b1;
    t_acc = accept_edge(a);
    exp_q.push_back('{t_acc, 5'b01000, 5'b00000});
    step(30 * TD);
    b = edge_n;
    btn_in_i[BTN_LEFT] = 1'b0;
    t_rel = first_tick(b);
`ifdef BUTTON_BANK_AUTOREPEAT_EN
    for (int t = t_acc + RD * TD; t < t_rel; t += RP * TD)
      exp_q.push_back('{t, 5'b01000, 5'b00000});
`endif
    exp_q.push_back('{accept_edge(b), 5'b00000, 5'b01000});
    step(40);
    n_cmp++; if (level_o !== 5'b00000) begin n_bad++; $display("FAIL rpt_level: got %b want 00000", level_o); end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL autorepeat: no pulse, want edge %0d press %b release %b", x.e, x.p, x.r);
      end else begin
        o = obs_q.pop_front();
        if (o.e !== x.e || o.p !== x.p || o.r !== x.r) begin
          n_bad++;
          $display("FAIL autorepeat: got edge %0d press %b release %b, want edge %0d press %b release %b",
                   o.e, o.p, o.r, x.e, x.p, x.r);
        end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL autorepeat_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    rst_i    = 1'b1;
    btn_in_i = '0;
    test_reset();
    test_clean_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_autorepeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
